// File: rtl/cnu_msa_pipe.sv
// Min-sum check node unit (plain/offset/normalised) over CN_DEGREE sign-magnitude edges.
// Latency: 3 register stages; a beat accepted at edge N shows out_valid after edge N+2; 1 beat/cycle.
// Backpressure: a single advance enable freezes every stage while out_valid && !out_ready; in_ready mirrors it.
//
// Ports:
//   sys_clk, rstn            clock, synchronous active-low reset
//   in_valid/in_ready        input handshake; in_msg (v2c, edge i at [i*QUAN_SIZE +: QUAN_SIZE]), in_tag, corr_mode
//   out_valid/out_ready      output handshake; out_msg (c2v, same packing), out_tag
//   busy                     any stage holds a valid beat
module cnu_msa_pipe #(
    parameter int CN_DEGREE  = 6,
    parameter int QUAN_SIZE  = 4,
    parameter int MAG_SIZE   = QUAN_SIZE - 1,
    parameter int OFFSET     = 1,
    parameter int NORM_SHIFT = 2,
    parameter int TAG_W      = 8
) (
    input  logic                           sys_clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CN_DEGREE*QUAN_SIZE-1:0] in_msg,
    input  logic [TAG_W-1:0]               in_tag,
    input  logic [1:0]                     corr_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CN_DEGREE*QUAN_SIZE-1:0] out_msg,
    output logic [TAG_W-1:0]               out_tag,
    output logic                           busy
);

    localparam int IDX_W = (CN_DEGREE > 1) ? $clog2(CN_DEGREE) : 1;
    localparam logic [MAG_SIZE-1:0] OFF_M = MAG_SIZE'(OFFSET);

    logic en;

    // Stage 1: split magnitudes and signs
    logic                                s1_vld;
    logic [CN_DEGREE-1:0][MAG_SIZE-1:0]  s1_mag;
    logic [CN_DEGREE-1:0]                s1_sgn;
    logic [TAG_W-1:0]                    s1_tag;
    logic [1:0]                          s1_mode;

    // Stage 2: two smallest magnitudes, position of the smallest, parity of all signs
    logic                                s2_vld;
    logic [MAG_SIZE-1:0]                 s2_min1;
    logic [MAG_SIZE-1:0]                 s2_min2;
    logic [IDX_W-1:0]                    s2_idx;
    logic                                s2_tsgn;
    logic [CN_DEGREE-1:0]                s2_sgn;
    logic [TAG_W-1:0]                    s2_tag;
    logic [1:0]                          s2_mode;

    logic [CN_DEGREE-1:0][MAG_SIZE-1:0]  in_mag;
    logic [CN_DEGREE-1:0]                in_sgn;
    logic [MAG_SIZE-1:0]                 min1, min2;
    logic [IDX_W-1:0]                    idx;
    logic                                tsgn;
    logic [MAG_SIZE-1:0]                 raw, cor;
    logic                                osgn;
    logic [CN_DEGREE*QUAN_SIZE-1:0]      nxt_msg;

    // The stage at the tail is the only one that can be blocked; when it holds an
    // unaccepted beat everything upstream must freeze too.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = rstn && en;
    assign busy     = s1_vld || s2_vld || out_valid;

    always_comb begin
        in_mag = '0;
        in_sgn = '0;
        for (int i = 0; i < CN_DEGREE; i++) begin
            in_mag[i] = in_msg[i*QUAN_SIZE +: MAG_SIZE];
            in_sgn[i] = in_msg[i*QUAN_SIZE + QUAN_SIZE - 1];
        end
    end

    // Strict '<' against min1 keeps the lowest index on ties; an equal value then
    // falls through to min2, which yields min2 == min1 for duplicate minima.
    always_comb begin
        min1 = '1;
        min2 = '1;
        idx  = '0;
        tsgn = ^s1_sgn;
        for (int i = 0; i < CN_DEGREE; i++) begin
            if (s1_mag[i] < min1) begin
                min2 = min1;
                min1 = s1_mag[i];
                idx  = IDX_W'(i);
            end else if (s1_mag[i] < min2) begin
                min2 = s1_mag[i];
            end
        end
    end

    always_comb begin
        nxt_msg = '0;
        raw     = '0;
        cor     = '0;
        osgn    = 1'b0;
        for (int i = 0; i < CN_DEGREE; i++) begin
            raw = (s2_idx == IDX_W'(i)) ? s2_min2 : s2_min1;
            case (s2_mode)
                2'd1:    cor = (raw > OFF_M) ? (raw - OFF_M) : '0;
                2'd2:    cor = raw - (raw >> NORM_SHIFT);
                default: cor = raw;
            endcase
            // A zero magnitude is always emitted as +0.
            osgn = (cor != '0) && (s2_tsgn ^ s2_sgn[i]);
            nxt_msg[i*QUAN_SIZE +: QUAN_SIZE] = {osgn, cor};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            s1_vld    <= 1'b0;
            s1_mag    <= '0;
            s1_sgn    <= '0;
            s1_tag    <= '0;
            s1_mode   <= '0;
            s2_vld    <= 1'b0;
            s2_min1   <= '0;
            s2_min2   <= '0;
            s2_idx    <= '0;
            s2_tsgn   <= 1'b0;
            s2_sgn    <= '0;
            s2_tag    <= '0;
            s2_mode   <= '0;
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_tag   <= '0;
        end else if (en) begin
            s1_vld    <= in_valid;
            s1_mag    <= in_mag;
            s1_sgn    <= in_sgn;
            s1_tag    <= in_tag;
            s1_mode   <= corr_mode;
            s2_vld    <= s1_vld;
            s2_min1   <= min1;
            s2_min2   <= min2;
            s2_idx    <= idx;
            s2_tsgn   <= tsgn;
            s2_sgn    <= s1_sgn;
            s2_tag    <= s1_tag;
            s2_mode   <= s1_mode;
            out_valid <= s2_vld;
            out_msg   <= nxt_msg;
            out_tag   <= s2_tag;
        end
    end

endmodule
